// File: rtl/iter_divider_if.sv
// Request/response bundle between the mult/div controller and the iterative divider.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             valid;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, valid, is_signed, a, b,
    input  ready, busy, done, hi, lo
  );

  modport slave (
    input  flush, valid, is_signed, a, b,
    output ready, busy, done, hi, lo
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign-corrected quotient on lo and remainder on hi with a one-cycle done pulse.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  iter_divider_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  // quo_q starts as the dividend; its MSB feeds the remainder as quotient bits shift in.
  always_comb begin
    accept = (state_q != StRun) && bus.valid && !bus.flush;
    a_neg  = bus.is_signed & bus.a[WIDTH-1];
    b_neg  = bus.is_signed & bus.b[WIDTH-1];
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_neg ? -bus.a : bus.a;
          dvs_d   = b_neg ? -bus.b : bus.b;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (bus.b == '0);
          a_d     = bus.a;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StDone;
            // Divide by zero bypasses sign correction and returns the raw dividend.
            lo_d    = dz_q ? '1   : (qneg_q ? -quo_nx : quo_nx);
            hi_d    = dz_q ? a_q  : (rneg_q ? -rem_nx : rem_nx);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready = (state_q == StIdle) || (state_q == StDone);
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
